mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single core-side memory port between NUM_REQ requesters (e.g. I-cache refill, D-cache miss/writeback, uncached LSU) using valid/ready handshakes on every channel.
- Round-robin arbitration with exactly one transaction outstanding; the grant is held until the response handshake completes.
- Sits between the cache/LSU request ports and the bus bridge.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 has initial priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- req_wstrb_i  in  NUM_REQ*DATA_W/8  packed byte strobes.
- resp_valid_o  out  NUM_REQ  response valid, routed to the owner only.
- resp_ready_i  in  NUM_REQ  per-requester response ready.
- resp_rdata_o  out  DATA_W  read data, broadcast; qualified by resp_valid_o.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream request ready.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  ADDR_W  downstream address.
- mem_wdata_o  out  DATA_W  downstream write data.
- mem_wstrb_o  out  DATA_W/8  downstream byte strobes.
- mem_resp_valid_i  in  1  downstream response valid; writes also return one response beat.
- mem_resp_ready_o  out  1  downstream response ready.
- mem_resp_rdata_i  in  DATA_W  downstream read data.
- busy_o  out  1  high whenever the arbiter is not in IDLE.

Behaviour:
- States:
  - IDLE: no transaction.
  - ISSUE: payload latched, presenting the request downstream.
  - RESP: request issued, awaiting the response.
- Reset (synchronous, rst_i=1 at an edge):
  - state=IDLE, prio_ptr=0, owner=0, latched payload=0.
  - All outputs 0: req_ready_o, resp_valid_o, mem_req_valid_o, mem_resp_ready_o, busy_o, mem_addr_o/wdata/wstrb/we.
  - Reset mid-transaction abandons it silently; no response is forwarded.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning prio_ptr, prio_ptr+1, … modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle. req_ready_o depends on valid; valid never depends on ready.
  - On that edge: latch we/addr/wdata/wstrb of the winner, set owner=winner, go to ISSUE.
  - No valid: stay in IDLE with all ready bits 0.
- ISSUE:
  - mem_req_valid_o=1, driving the latched payload; the payload is stable while valid is high.
  - On mem_req_ready_i=1: go to RESP.
  - req_ready_o is all 0.
- RESP:
  - resp_valid_o[owner]=mem_resp_valid_i; every other resp_valid_o bit is 0.
  - mem_resp_ready_o=resp_ready_i[owner]; resp_rdata_o=mem_resp_rdata_i passed through combinationally.
  - On mem_resp_valid_i & resp_ready_i[owner]: go to IDLE, prio_ptr=(owner+1) mod NUM_REQ.
- Latency:
  - Accept at cycle T; mem_req_valid_o earliest at T+1.
  - Response forwarded in the same cycle it arrives.
  - Next accept possible in the cycle after the response handshake.
  - Minimum 3 cycles per transaction with a zero-wait downstream.
- Fairness: a requester holding valid is granted within NUM_REQ transactions.
- Requesters hold valid and payload until ready (standard handshake). Payload changes after acceptance have no effect.
- mem_resp_valid_i while not in RESP is a protocol error: ignored, mem_resp_ready_o=0.
- prio_ptr wraps from NUM_REQ-1 to 0.
- Owner back-pressure: resp_ready_i[owner]=0 holds RESP indefinitely; no other grant is made.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles with all req_valid_i=1 -> every output 0 and state IDLE; first grant after release goes to requester 0.
- Single read: req 1 valid, addr=0x8000_0010, zero-wait memory returning 0xDEADBEEF -> req_ready_o=0b10 at T, mem_req_valid_o at T+1 with addr 0x8000_0010, resp_valid_o=0b10 with rdata 0xDEADBEEF, busy_o low after the handshake.
- Contention round-robin: both requesters hold valid continuously, 4 transactions -> grant order 0,1,0,1; no requester is granted twice in a row.
- Downstream stall: mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o stays 1 with stable addr/wdata/wstrb; req 0 stays unaccepted; the issue completes on the 6th cycle.
- Write with strobe: req 0 writes wdata=0x11223344, wstrb=0b0101; owner holds resp_ready_i=0 for 3 cycles -> mem_we_o=1 and wstrb=0b0101 downstream; mem_resp_ready_o=0 during the hold; return to IDLE only after resp_ready_i rises.
- Reset mid-RESP: assert rst_i while in RESP with mem_resp_valid_i=1 -> no resp_valid_o pulse in the following cycle; prio_ptr=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one core-side memory port between NUM_REQ requesters (I-cache refill,
// D-cache miss/writeback, uncached LSU). Round-robin arbitration with exactly
// one transaction in flight; the grant is held until the response handshake.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester request handshake
//   req_we/addr/wdata/wstrb packed per-requester payload (slice k = requester k)
//   resp_valid_o/ready_i    per-requester response handshake (owner only)
//   resp_rdata_o            read data, broadcast, qualified by resp_valid_o
//   mem_req_*               downstream request channel (latched payload)
//   mem_resp_*              downstream response channel (writes also return a beat)
//   busy_o                  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [DATA_W-1:0]             resp_rdata_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_wstrb_o,
    input  logic                          mem_resp_valid_i,
    output logic                          mem_resp_ready_o,
    input  logic [DATA_W-1:0]             mem_resp_rdata_i,
    output logic                          busy_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  prio_ptr;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  winner;
    logic              found;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [STRB_W-1:0] wstrb_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
        assign wstrb_arr[k] = req_wstrb_i[k*STRB_W +: STRB_W];
    end

    // Round-robin search: first valid requester starting at prio_ptr, wrapping.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[IDX_W'((int'(prio_ptr) + i) % NUM_REQ)]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(prio_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Ready follows valid in the same cycle; gated by reset so that a held
    // reset presents all-zero outputs even with requests pending.
    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state == IDLE && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Response is routed to the owner only and passed through unregistered.
    always_comb begin
        resp_valid_o = '0;
        if (!rst_i && state == RESP) begin
            resp_valid_o[owner] = mem_resp_valid_i;
        end
    end

    assign mem_resp_ready_o = !rst_i && (state == RESP) && resp_ready_i[owner];
    assign resp_rdata_o     = mem_resp_rdata_i;
    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wstrb_o      = wstrb_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            prio_ptr        <= '0;
            owner           <= '0;
            // NOTE: the payload registers drive outputs directly, so they are
            // reset explicitly to keep the downstream port at zero.
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            mem_req_valid_o <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner           <= winner;
                        we_q            <= req_we_i[winner];
                        addr_q          <= addr_arr[winner];
                        wdata_q         <= wdata_arr[winner];
                        wstrb_q         <= wstrb_arr[winner];
                        state           <= ISSUE;
                        mem_req_valid_o <= 1'b1;
                        busy_o          <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        state           <= RESP;
                        mem_req_valid_o <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_resp_valid_i && resp_ready_i[owner]) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        prio_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    mem_req_valid_o <= 1'b0;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule
